lfsr_rng_arbiter: RTL and testbench
===================================

Name: lfsr_rng_arbiter

Overview:
Shared random-number server. Owns one 16-bit maximal-length Fibonacci LFSR and hands its values to N_REQ requesters through a round-robin req/gnt handshake. Game logic (spawners, AI, effects) requests values here instead of instantiating private LFSRs. The LFSR advances only on demand, STEPS shifts per grant, so consecutive grants are decorrelated and sequences are reproducible from a seed.

Parameters:
N_REQ, 4, number of requesters (2..8)
STEPS, 4, LFSR shifts performed between winner selection and grant (1..15)
DEFAULT_SEED, 16'h0040, LFSR value after reset and replacement for an all-zero seed

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low; low clears all state immediately
seed_load  input  1  reload request, sampled only in IDLE
seed  input  16  value loaded into LFSR on accepted seed_load
req  input  N_REQ  per-requester request level; hold until own gnt bit seen
gnt  output  N_REQ  one-hot grant, exactly one cycle
rnd_data  output  16  random value, valid while rnd_valid=1; holds last value otherwise
rnd_valid  output  1  high for the single GRANT cycle, coincident with gnt
busy  output  1  high whenever state != IDLE
seed_err  output  1  one-cycle pulse: accepted seed was 16'h0000

Behaviour:
- LFSR shift: lfsr <= {lfsr[14:0], lfsr[15]^lfsr[14]^lfsr[12]^lfsr[3]}; shifts only in STEP. Polynomial is maximal; zero unreachable from nonzero.
- Reset (reset=0, async): lfsr=DEFAULT_SEED, state=IDLE, rr_ptr=0, step_cnt=0, winner=0, gnt=0, rnd_valid=0, rnd_data=16'h0000, busy=0, seed_err=0.
- States: IDLE, LOAD, STEP, GRANT. All outputs registered.
- IDLE: seed_load=1 -> LOAD (priority over req). Else |req -> latch winner = first set req bit searching from rr_ptr upward with wrap; step_cnt=STEPS-1; -> STEP. Else stay.
- LOAD (1 cycle): lfsr <= (seed==0) ? DEFAULT_SEED : seed; seed_err pulses in the same cycle when seed==0; -> IDLE.
- STEP: shift once per cycle; step_cnt==0 -> GRANT, else decrement.
- GRANT (1 cycle): gnt = one-hot(winner), rnd_data = lfsr (post-shift value), rnd_valid=1; rr_ptr <= (winner+1) mod N_REQ; -> IDLE.
- Latency: req first high in IDLE cycle t -> gnt/rnd_valid high in cycle t+STEPS+1. Minimum grant spacing STEPS+2 cycles.
- Winner latched at selection: if its req drops before GRANT, grant still issued; other requesters stay queued.
- seed_load outside IDLE is ignored (not queued); software checks busy before loading.
- seed_load and req together in IDLE: LOAD first, request arbitrated on return to IDLE (req still held).
- Round-robin: a requester holding req is granted within N_REQ grants; no requester granted twice while another holds req.
- Reset mid-STEP or mid-GRANT: pending grant dropped, gnt/rnd_valid deassert immediately (async), LFSR returns to DEFAULT_SEED.

Test Plan:
- Reset release, req=4'b0001 at cycle t -> gnt=4'b0001, rnd_valid=1, rnd_data=16'h0400 at cycle t+5; busy high t+1..t+5.
- Hold req=4'b0001 for second grant -> rnd_data=16'h4002 (path 0x0800,0x1000,0x2001,0x4002); gap between grants 6 cycles.
- req=4'b1111 held, rr_ptr=0 -> grant order 0,1,2,3,0; no gnt ever has more than one bit set.
- seed_load=1, seed=16'h8000 in IDLE, then req[2] -> LOAD, then gnt=4'b0100 with rnd_data=16'h0008 (0x0001,0x0002,0x0004,0x0008); seed=16'h0000 -> seed_err pulse, next grant equals post-reset first value 16'h0400.
- seed_load during STEP -> ignored; LFSR sequence unchanged; seed_load together with req in IDLE -> LOAD precedes grant.
- Assert reset low mid-STEP -> gnt=0, rnd_valid=0, busy=0 same cycle; after release first grant returns 16'h0400.

Source files
------------

// File: rtl/lfsr_rng_arbiter.sv
// Shared random-number server: one 16-bit Fibonacci LFSR handed out to N_REQ
// requesters through a round-robin req/gnt handshake, STEPS shifts per grant.
module lfsr_rng_arbiter #(
    parameter int          N_REQ        = 4,
    parameter int          STEPS        = 4,
    parameter logic [15:0] DEFAULT_SEED = 16'h0040
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             seed_load,
    input  logic [15:0]      seed,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [15:0]      rnd_data,
    output logic             rnd_valid,
    output logic             busy,
    output logic             seed_err
);

    localparam int W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_STEP  = 2'd2,
        S_GRANT = 2'd3
    } state_t;

    state_t             state_q;
    logic [15:0]        lfsr_q;
    logic [15:0]        seed_q;
    logic [W-1:0]       rr_ptr_q;
    logic [W-1:0]       winner_q;
    logic [3:0]         step_cnt_q;
    logic [N_REQ-1:0]   gnt_q;
    logic [15:0]        rnd_data_q;
    logic               rnd_valid_q;
    logic               busy_q;
    logic               seed_err_q;

    logic [15:0]        lfsr_d;
    logic [W-1:0]       pick_d;
    logic [N_REQ-1:0]   gnt_d;
    logic [W-1:0]       cand;
    logic               found;

    assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[14] ^ lfsr_q[12] ^ lfsr_q[3]};
    assign gnt_d  = {{(N_REQ-1){1'b0}}, 1'b1} << winner_q;

    // First asserted request at or above rr_ptr, wrapping around.
    always_comb begin
        pick_d = '0;
        found  = 1'b0;
        cand   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = W'((int'(rr_ptr_q) + i) % N_REQ);
            if (!found && req[cand]) begin
                pick_d = cand;
                found  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            lfsr_q      <= DEFAULT_SEED;
            seed_q      <= '0;
            rr_ptr_q    <= '0;
            winner_q    <= '0;
            step_cnt_q  <= '0;
            gnt_q       <= '0;
            rnd_data_q  <= '0;
            rnd_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            seed_err_q  <= 1'b0;
        end else begin
            gnt_q       <= '0;
            rnd_valid_q <= 1'b0;
            seed_err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (seed_load) begin
                        seed_q     <= seed;
                        seed_err_q <= (seed == 16'h0000);
                        busy_q     <= 1'b1;
                        state_q    <= S_LOAD;
                    end else if (|req) begin
                        winner_q   <= pick_d;
                        step_cnt_q <= 4'(STEPS - 1);
                        busy_q     <= 1'b1;
                        state_q    <= S_STEP;
                    end
                end
                S_LOAD: begin
                    lfsr_q  <= (seed_q == 16'h0000) ? DEFAULT_SEED : seed_q;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                S_STEP: begin
                    lfsr_q <= lfsr_d;
                    if (step_cnt_q == 4'd0) begin
                        // Outputs are registered, so the grant is loaded on the last shift.
                        gnt_q       <= gnt_d;
                        rnd_data_q  <= lfsr_d;
                        rnd_valid_q <= 1'b1;
                        state_q     <= S_GRANT;
                    end else begin
                        step_cnt_q <= step_cnt_q - 4'd1;
                    end
                end
                S_GRANT: begin
                    rr_ptr_q <= (winner_q == W'(N_REQ - 1)) ? '0 : winner_q + W'(1);
                    busy_q   <= 1'b0;
                    state_q  <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign rnd_data  = rnd_data_q;
    assign rnd_valid = rnd_valid_q;
    assign busy      = busy_q;
    assign seed_err  = seed_err_q;

endmodule

// File: tb/tb_lfsr_rng_arbiter.sv
// Self-checking bench for lfsr_rng_arbiter: directed steps then randomized
// transactions, checked against a transaction-level model of the server.
module tb_lfsr_rng_arbiter;

    localparam int          N     = 4;
    localparam int          STEPS = 4;
    localparam logic [15:0] DSEED = 16'h0040;

    logic          clk;
    logic          reset;
    logic          seed_load;
    logic [15:0]   seed;
    logic [N-1:0]  req;
    logic [N-1:0]  gnt;
    logic [15:0]   rnd_data;
    logic          rnd_valid;
    logic          busy;
    logic          seed_err;

    int checks = 0;
    int errors = 0;

    logic [15:0] m_lfsr;
    int          m_rr;

    lfsr_rng_arbiter #(.N_REQ(N), .STEPS(STEPS), .DEFAULT_SEED(DSEED)) dut (
        .clk       (clk),
        .reset     (reset),
        .seed_load (seed_load),
        .seed      (seed),
        .req       (req),
        .gnt       (gnt),
        .rnd_data  (rnd_data),
        .rnd_valid (rnd_valid),
        .busy      (busy),
        .seed_err  (seed_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[14] ^ v[12] ^ v[3]};
    endfunction

    function automatic int model_pick(input logic [N-1:0] m);
        for (int i = 0; i < N; i++)
            if (m[(m_rr + i) % N]) return (m_rr + i) % N;
        return -1;
    endfunction

    // mode 0: plain, 1: drop req after selection, 2: pulse seed_load during STEP
    task automatic grant_txn(input logic [N-1:0] mask, input int mode, input string tag);
        int          n;
        int          w;
        logic [15:0] exp_val;
        logic [N-1:0] oh;
        req     = mask;
        w       = model_pick(mask);
        exp_val = m_lfsr;
        for (int k = 0; k < STEPS; k++) exp_val = lfsr_next(exp_val);
        oh = '0;
        if (w >= 0) oh[w] = 1'b1;
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (mode == 1 && n == 1) req = '0;
            if (mode == 2 && n == 1) begin
                seed_load = 1'b1;
                seed      = 16'($urandom);
            end
            if (mode == 2 && n == 2) seed_load = 1'b0;
            if (gnt != '0) break;
            chk(32'(busy), 32'd1, {tag, "_busy_wait"});
        end
        seed_load = 1'b0;
        chk(32'(n), 32'(STEPS + 1), {tag, "_latency"});
        chk(32'(gnt), 32'(oh), {tag, "_gnt"});
        chk(32'($onehot(gnt)), 32'd1, {tag, "_onehot"});
        chk(32'(rnd_valid), 32'd1, {tag, "_valid"});
        chk(32'(rnd_data), 32'(exp_val), {tag, "_data"});
        chk(32'(busy), 32'd1, {tag, "_busy_grant"});
        @(negedge clk);
        chk(32'(gnt), 32'd0, {tag, "_gnt_clear"});
        chk(32'(rnd_valid), 32'd0, {tag, "_valid_clear"});
        chk(32'(rnd_data), 32'(exp_val), {tag, "_data_hold"});
        chk(32'(busy), 32'd0, {tag, "_busy_idle"});
        m_lfsr = exp_val;
        if (w >= 0) m_rr = (w + 1) % N;
    endtask

    task automatic load_seed(input logic [15:0] s, input logic [N-1:0] mask, input string tag);
        seed_load = 1'b1;
        seed      = s;
        req       = mask;
        @(negedge clk);
        seed_load = 1'b0;
        chk(32'(busy), 32'd1, {tag, "_busy_load"});
        chk(32'(seed_err), 32'(s == 16'h0000), {tag, "_seed_err"});
        @(negedge clk);
        chk(32'(busy), 32'd0, {tag, "_busy_after"});
        chk(32'(seed_err), 32'd0, {tag, "_seed_err_clear"});
        chk(32'(gnt), 32'd0, {tag, "_no_gnt"});
        m_lfsr = (s == 16'h0000) ? DSEED : s;
    endtask

    initial begin
        reset     = 1'b0;
        seed_load = 1'b0;
        seed      = '0;
        req       = '0;
        m_lfsr    = DSEED;
        m_rr      = 0;
        repeat (3) @(negedge clk);
        chk(32'(gnt), 32'd0, "rst_gnt");
        chk(32'(rnd_valid), 32'd0, "rst_valid");
        chk(32'(rnd_data), 32'd0, "rst_data");
        chk(32'(busy), 32'd0, "rst_busy");
        chk(32'(seed_err), 32'd0, "rst_seed_err");
        reset = 1'b1;
        @(negedge clk);

        grant_txn(4'b0001, 0, "first");
        chk(32'(rnd_data), 32'h0400, "first_const");
        grant_txn(4'b0001, 0, "second");
        chk(32'(rnd_data), 32'h4002, "second_const");

        // Reset in the middle of the STEP phase
        req = 4'b0100;
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk(32'(gnt), 32'd0, "midrst_gnt");
        chk(32'(rnd_valid), 32'd0, "midrst_valid");
        chk(32'(busy), 32'd0, "midrst_busy");
        chk(32'(rnd_data), 32'd0, "midrst_data");
        req = '0;
        @(negedge clk);
        reset  = 1'b1;
        m_lfsr = DSEED;
        m_rr   = 0;
        @(negedge clk);

        grant_txn(4'b1111, 0, "rr0");
        chk(32'(rnd_data), 32'h0400, "rr0_const");
        grant_txn(4'b1111, 0, "rr1");
        grant_txn(4'b1111, 0, "rr2");
        grant_txn(4'b1111, 0, "rr3");
        grant_txn(4'b1111, 0, "rr4");

        load_seed(16'h8000, 4'b0100, "seed8000");
        grant_txn(4'b0100, 0, "seed8000_gnt");
        chk(32'(rnd_data), 32'h0008, "seed8000_const");

        load_seed(16'h0000, 4'b0000, "seed0");
        grant_txn(4'b0001, 0, "seed0_gnt");
        chk(32'(rnd_data), 32'h0400, "seed0_const");

        grant_txn(4'b0010, 2, "ld_in_step");
        grant_txn(4'b1000, 1, "drop_req");
        grant_txn(4'b0110, 0, "after_drop");

        for (int it = 0; it < 30; it++) begin
            logic [N-1:0] mask;
            mask = N'($urandom_range(1, (1 << N) - 1));
            if ($urandom_range(0, 4) == 0) begin
                if ($urandom_range(0, 3) == 0) load_seed(16'h0000, mask, "rnd_seed");
                else load_seed(16'($urandom), mask, "rnd_seed");
            end
            grant_txn(mask, int'($urandom_range(0, 2)), "rnd");
        end
        req = '0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
